// File: rtl/z80_decode_exec_unit_if.sv
// Bundle between the instruction register / timing sequencer and the Z80
// decode-execute block. The master drives the prefix, opcode and machine
// timing. The slave returns the registered PLA vector and the execute strobes.
interface z80_decode_exec_unit_if;
    logic [4:0]  prefix;
    logic [7:0]  opcode;
    logic [5:0]  mcyc;
    logic [5:0]  tst;
    logic [23:0] pla;
    logic        nextM;
    logic        setM1;
    logic        setM1ss;
    logic        setM1cc;
    logic        setM1bz;
    logic        fFetch;
    logic        fMRead;
    logic        fMWrite;
    logic        fIORead;
    logic        fIOWrite;
    logic        fIntr;
    logic        ctl_bus_sw1;
    logic        ctl_bus_sw2;
    logic        ctl_bus_sw4;
    logic        ctl_al_we;
    logic        ctl_inc_dec;
    logic        ctl_inc_limit6;
    logic        ctl_inc_cy;
    logic        ctl_ab_mux_inc;
    logic        explode;

    modport master (
        output prefix, opcode, mcyc, tst,
        input  pla, nextM, setM1, setM1ss, setM1cc, setM1bz,
        input  fFetch, fMRead, fMWrite, fIORead, fIOWrite, fIntr,
        input  ctl_bus_sw1, ctl_bus_sw2, ctl_bus_sw4, ctl_al_we, ctl_inc_dec,
        input  ctl_inc_limit6, ctl_inc_cy, ctl_ab_mux_inc, explode
    );

    modport slave (
        input  prefix, opcode, mcyc, tst,
        output pla, nextM, setM1, setM1ss, setM1cc, setM1bz,
        output fFetch, fMRead, fMWrite, fIORead, fIOWrite, fIntr,
        output ctl_bus_sw1, ctl_bus_sw2, ctl_bus_sw4, ctl_al_we, ctl_inc_dec,
        output ctl_inc_limit6, ctl_inc_cy, ctl_ab_mux_inc, explode
    );
endinterface

// File: rtl/z80_decode_exec_unit.sv
// Z80 instruction decode into a registered 24-line PLA vector. The execute
// controls (cycle type, sequencing, bus strobes) are derived combinationally
// from that vector and the current one-hot machine cycle / T-state.
module z80_decode_exec_unit (
    input  logic                    clk,
    input  logic                    reset,
    z80_decode_exec_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        CY_NONE, CY_FETCH, CY_MREAD, CY_MWRITE, CY_IORD, CY_IOWR, CY_INTERNAL
    } cycle_e;

    typedef enum logic [1:0] {END_M1, END_SS, END_CC, END_BZ} end_e;

    logic [23:0] dec;
    logic [23:0] pla_q;
    logic [7:0]  op;
    logic [1:0]  op_x;
    logic [2:0]  op_y;
    logic [2:0]  op_z;
    logic        table_ok;

    cycle_e      cyc;
    end_e        end_kind;
    logic [2:0]  cyc_len;
    logic [2:0]  t_num;
    logic        rd_plus;
    logic        is_final;
    logic        single_m;
    logic        mt_ok;
    logic        in_range;
    logic        last_t;
    logic        m1;
    logic        fin_t;
    logic        f_mread;
    logic        f_mwrite;
    logic        f_ioread;
    logic        f_iowrite;
    logic        inc_cy;

    assign op       = bus.opcode;
    assign op_x     = op[7:6];
    assign op_y     = op[5:3];
    assign op_z     = op[2:0];
    assign table_ok = $onehot(bus.prefix[2:0]) && $onehot(bus.prefix[4:3]);

    // Opcode decode for the selected table; anything not matched is undecoded (p23).
    always_comb begin
        dec = '0;
        if (table_ok) begin
            if (bus.prefix[2]) begin
                dec[0]  = (op_x == 2'b01) && (op_y != 3'b110) && (op_z != 3'b110);
                dec[1]  = (op_x == 2'b01) && (op_y != 3'b110) && (op_z == 3'b110);
                dec[2]  = (op_x == 2'b01) && (op_y == 3'b110) && (op_z != 3'b110);
                dec[3]  = (op == 8'h76);
                dec[4]  = (op_x == 2'b00) && (op_y != 3'b110) && (op_z == 3'b110);
                dec[5]  = (op == 8'h36);
                dec[6]  = (op_x == 2'b10) && (op_z != 3'b110);
                dec[7]  = (op_x == 2'b10) && (op_z == 3'b110);
                dec[8]  = (op_x == 2'b11) && (op_z == 3'b110);
                dec[9]  = (op_x == 2'b00) && (op_y != 3'b110) && (op_z[2:1] == 2'b10);
                dec[10] = (op == 8'hC3);
                dec[11] = (op_x == 2'b11) && (op_z == 3'b010);
                dec[12] = (op == 8'h18);
                dec[13] = (op == 8'h10);
                dec[14] = (op == 8'hD3);
                dec[15] = (op == 8'hDB);
                dec[16] = (op == 8'h00);
            end
            if (bus.prefix[1]) begin
                dec[17] = (op_x == 2'b00);
                dec[18] = (op_x != 2'b00);
            end
            if (bus.prefix[0]) begin
                dec[19] = (op_x == 2'b01) && (op_z == 3'b000);
                dec[20] = (op_x == 2'b01) && (op_z == 3'b001);
                dec[21] = (op_x == 2'b10) && op_y[2] && (op_z == 3'b000);
            end
            dec[22] = bus.prefix[3] &&
                      (dec[1] || dec[2] || dec[5] || dec[7] ||
                       (bus.prefix[2] && ((op == 8'h34) || (op == 8'h35))) ||
                       (bus.prefix[1] && (op_z == 3'b110)));
            dec[23] = ~|dec[21:0];
        end else begin
            dec[23] = 1'b1;
        end
    end

    // PLA register: one clock of decode latency, NOP after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pla_q <= 24'h010000;
        end else begin
            pla_q <= dec;
        end
    end

    // T-state number (1..6) from the one-hot T vector.
    always_comb begin
        t_num = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (bus.tst[i]) begin
                t_num = 3'(i + 1);
            end
        end
    end

    assign single_m = pla_q[0] | pla_q[3] | pla_q[6] | pla_q[9] | pla_q[16] |
                      pla_q[17] | pla_q[18] | pla_q[23];

    // Describe the current machine cycle of the decoded instruction: type, length, finality.
    always_comb begin
        cyc      = CY_NONE;
        cyc_len  = 3'd0;
        rd_plus  = 1'b0;
        is_final = 1'b0;
        end_kind = END_M1;
        if (pla_q[3]) begin
            end_kind = END_SS;
        end else if (pla_q[11]) begin
            end_kind = END_CC;
        end else if (pla_q[21]) begin
            end_kind = END_BZ;
        end
        if (bus.mcyc[0]) begin
            cyc      = CY_FETCH;
            cyc_len  = pla_q[13] ? 3'd5 : 3'd4;
            is_final = single_m;
        end else if (bus.mcyc[1]) begin
            if (pla_q[4] | pla_q[8]) begin
                cyc = CY_MREAD;  cyc_len = 3'd3; rd_plus = 1'b1; is_final = 1'b1;
            end else if (pla_q[1] | pla_q[7]) begin
                cyc = CY_MREAD;  cyc_len = 3'd3; is_final = 1'b1;
            end else if (pla_q[2]) begin
                cyc = CY_MWRITE; cyc_len = 3'd3; is_final = 1'b1;
            end else if (|{pla_q[5], pla_q[15:10]}) begin
                cyc = CY_MREAD;  cyc_len = 3'd3; rd_plus = 1'b1;
            end else if (pla_q[19]) begin
                cyc = CY_IORD;   cyc_len = 3'd4; is_final = 1'b1;
            end else if (pla_q[20]) begin
                cyc = CY_IOWR;   cyc_len = 3'd4; is_final = 1'b1;
            end else if (pla_q[21]) begin
                cyc = CY_MREAD;  cyc_len = 3'd3;
            end
        end else if (bus.mcyc[2]) begin
            if (pla_q[5]) begin
                cyc = CY_MWRITE;   cyc_len = 3'd3; is_final = 1'b1;
            end else if (pla_q[10] | pla_q[11]) begin
                cyc = CY_MREAD;    cyc_len = 3'd3; rd_plus = 1'b1; is_final = 1'b1;
            end else if (pla_q[12] | pla_q[13]) begin
                cyc = CY_INTERNAL; cyc_len = 3'd5; is_final = 1'b1;
            end else if (pla_q[14]) begin
                cyc = CY_IOWR;     cyc_len = 3'd4; is_final = 1'b1;
            end else if (pla_q[15]) begin
                cyc = CY_IORD;     cyc_len = 3'd4; is_final = 1'b1;
            end else if (pla_q[21]) begin
                cyc = CY_MWRITE;   cyc_len = 3'd5; is_final = 1'b1;
            end
        end
    end

    assign mt_ok     = $onehot(bus.mcyc) && $onehot(bus.tst);
    assign m1        = mt_ok && bus.mcyc[0];
    assign in_range  = mt_ok && (cyc != CY_NONE) && (t_num <= cyc_len);
    assign last_t    = in_range && (t_num == cyc_len);
    assign fin_t     = last_t && is_final;
    assign f_mread   = in_range && (cyc == CY_MREAD);
    assign f_mwrite  = in_range && (cyc == CY_MWRITE);
    assign f_ioread  = in_range && (cyc == CY_IORD);
    assign f_iowrite = in_range && (cyc == CY_IOWR);
    assign inc_cy    = mt_ok && bus.tst[1] && (bus.mcyc[0] || (in_range && rd_plus));

    assign bus.pla            = pla_q;
    assign bus.nextM          = last_t && !is_final;
    assign bus.setM1          = fin_t && (end_kind == END_M1);
    assign bus.setM1ss        = fin_t && (end_kind == END_SS);
    assign bus.setM1cc        = fin_t && (end_kind == END_CC);
    assign bus.setM1bz        = (fin_t && (end_kind == END_BZ)) ||
                                (mt_ok && pla_q[13] && bus.mcyc[1] && bus.tst[2]);
    assign bus.fFetch         = bus.mcyc[0];
    assign bus.fMRead         = f_mread;
    assign bus.fMWrite        = f_mwrite;
    assign bus.fIORead        = f_ioread;
    assign bus.fIOWrite       = f_iowrite;
    assign bus.fIntr          = 1'b0;
    assign bus.ctl_bus_sw1    = mt_ok && bus.tst[2] && (bus.mcyc[0] || f_mread || f_ioread);
    assign bus.ctl_bus_sw2    = f_mwrite || f_iowrite;
    assign bus.ctl_bus_sw4    = m1 && bus.tst[3];
    assign bus.ctl_al_we      = mt_ok && bus.tst[0];
    assign bus.ctl_inc_dec    = m1 && pla_q[13] && bus.tst[4];
    assign bus.ctl_inc_limit6 = m1 && bus.tst[2];
    assign bus.ctl_inc_cy     = inc_cy;
    assign bus.ctl_ab_mux_inc = inc_cy;
    assign bus.explode        = m1 && pla_q[23] && bus.tst[3];

endmodule

// File: tb/tb_z80_decode_exec_unit.sv
// Self-checking bench for z80_decode_exec_unit: directed scenarios, a full
// opcode sweep over every valid prefix, and randomized prefix/opcode/timing.
module tb_z80_decode_exec_unit;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    z80_decode_exec_unit_if bus ();

    z80_decode_exec_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Compare one observed value against the expected one and report a miss.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a prefix/opcode pair and let it through the PLA register.
    task automatic applyStimulus(input logic [4:0] pfx, input logic [7:0] opc);
        @(negedge clk);
        bus.prefix = pfx;
        bus.opcode = opc;
        @(posedge clk);
        #1;
    endtask

    task automatic setTiming(input int m, input int t);
        bus.mcyc = 6'(1 << (m - 1));
        bus.tst  = 6'(1 << (t - 1));
        #1;
    endtask

    // Reference decode: which instruction class the byte belongs to.
    function automatic logic [23:0] model_pla(input logic [4:0] pfx, input logic [7:0] opc);
        logic [23:0] r;
        int line;
        int x, y, z;
        r = '0;
        if (!($onehot(pfx[2:0]) && $onehot(pfx[4:3]))) return 24'h800000;
        x = int'(opc[7:6]);
        y = int'(opc[5:3]);
        z = int'(opc[2:0]);
        line = -1;
        if (pfx[2]) begin
            if (opc == 8'h76) line = 3;
            else if (opc == 8'h36) line = 5;
            else if (x == 1 && y != 6 && z != 6) line = 0;
            else if (x == 1 && z == 6) line = 1;
            else if (x == 1 && y == 6) line = 2;
            else if (x == 0 && z == 6 && y != 6) line = 4;
            else if (x == 2) line = (z != 6) ? 6 : 7;
            else if (x == 3 && z == 6) line = 8;
            else if (x == 0 && y != 6 && (z == 4 || z == 5)) line = 9;
            else if (opc == 8'hC3) line = 10;
            else if (x == 3 && z == 2) line = 11;
            else if (opc == 8'h18) line = 12;
            else if (opc == 8'h10) line = 13;
            else if (opc == 8'hD3) line = 14;
            else if (opc == 8'hDB) line = 15;
            else if (opc == 8'h00) line = 16;
        end else if (pfx[1]) begin
            line = (x == 0) ? 17 : 18;
        end else begin
            if (x == 1 && z == 0) line = 19;
            else if (x == 1 && z == 1) line = 20;
            else if (x == 2 && y >= 4 && z == 0) line = 21;
        end
        if (line >= 0) r[line] = 1'b1;
        else r[23] = 1'b1;
        if (pfx[3] && (line == 1 || line == 2 || line == 5 || line == 7 ||
                       (pfx[2] && (opc == 8'h34 || opc == 8'h35)) ||
                       (pfx[1] && z == 6))) r[22] = 1'b1;
        return r;
    endfunction

    function automatic int group_of(input logic [23:0] p);
        for (int i = 0; i < 22; i++) if (p[i]) return i;
        return 23;
    endfunction

    // Instruction timing table: number of M-cycles, end strobe kind, and the
    // type/length/"+" of the requested M-cycle. ty: F fetch, R read, W write,
    // I io read, O io write, N internal.
    function automatic void cyc_info(input int g, input int m, output byte ty, output int len,
                                     output bit plus, output int ncyc, output int endk);
        ty = "-"; len = 0; plus = 1'b0; ncyc = 1; endk = 0;
        case (g)
            1, 2, 4, 7, 8, 19, 20: ncyc = 2;
            5, 10, 11, 12, 13, 14, 15, 21: ncyc = 3;
            default: ncyc = 1;
        endcase
        if (g == 3) endk = 1;
        if (g == 11) endk = 2;
        if (g == 21) endk = 3;
        if (m == 1) begin
            ty = "F"; len = (g == 13) ? 5 : 4;
        end else if (m == 2) begin
            case (g)
                4, 8, 5, 10, 11, 12, 13, 14, 15: begin ty = "R"; len = 3; plus = 1'b1; end
                1, 7, 21: begin ty = "R"; len = 3; end
                2:        begin ty = "W"; len = 3; end
                19:       begin ty = "I"; len = 4; end
                20:       begin ty = "O"; len = 4; end
                default:  ;
            endcase
        end else if (m == 3) begin
            case (g)
                5:        begin ty = "W"; len = 3; end
                10, 11:   begin ty = "R"; len = 3; plus = 1'b1; end
                12, 13:   begin ty = "N"; len = 5; end
                14:       begin ty = "O"; len = 4; end
                15:       begin ty = "I"; len = 4; end
                21:       begin ty = "W"; len = 5; end
                default:  ;
            endcase
        end
    endfunction

    // Expected execute vector in the same bit order as dut_exec().
    function automatic logic [19:0] model_exec(input int g, input logic [5:0] mc, input logic [5:0] ts);
        byte ty;
        int len, ncyc, endk, m, t;
        bit plus, ex, inr, last, fin, fmr, fmw, fir, fiw, incy;
        logic [19:0] v;
        if (!($onehot(mc) && $onehot(ts))) begin
            v = '0;
            v[14] = mc[0];
            return v;
        end
        m = 0; t = 0;
        for (int i = 0; i < 6; i++) begin
            if (mc[i]) m = i + 1;
            if (ts[i]) t = i + 1;
        end
        cyc_info(g, m, ty, len, plus, ncyc, endk);
        ex   = (m <= ncyc);
        inr  = ex && (t <= len);
        last = ex && (t == len);
        fin  = last && (m == ncyc);
        fmr  = inr && ty == "R";
        fmw  = inr && ty == "W";
        fir  = inr && ty == "I";
        fiw  = inr && ty == "O";
        incy = (t == 2) && (m == 1 || (inr && plus));
        v[19] = last && (m < ncyc);
        v[18] = fin && endk == 0;
        v[17] = fin && endk == 1;
        v[16] = fin && endk == 2;
        v[15] = (fin && endk == 3) || (g == 13 && m == 2 && t == 3);
        v[14] = (m == 1);
        v[13] = fmr;
        v[12] = fmw;
        v[11] = fir;
        v[10] = fiw;
        v[9]  = 1'b0;
        v[8]  = (t == 3) && (m == 1 || fmr || fir);
        v[7]  = fmw || fiw;
        v[6]  = (m == 1 && t == 4);
        v[5]  = (t == 1);
        v[4]  = (g == 13 && m == 1 && t == 5);
        v[3]  = (m == 1 && t == 3);
        v[2]  = incy;
        v[1]  = incy;
        v[0]  = (g == 23 && m == 1 && t == 4);
        return v;
    endfunction

    function automatic logic [19:0] dut_exec();
        return {bus.nextM, bus.setM1, bus.setM1ss, bus.setM1cc, bus.setM1bz,
                bus.fFetch, bus.fMRead, bus.fMWrite, bus.fIORead, bus.fIOWrite, bus.fIntr,
                bus.ctl_bus_sw1, bus.ctl_bus_sw2, bus.ctl_bus_sw4, bus.ctl_al_we,
                bus.ctl_inc_dec, bus.ctl_inc_limit6, bus.ctl_inc_cy, bus.ctl_ab_mux_inc,
                bus.explode};
    endfunction

    function automatic int line_count(input logic [23:0] p);
        int n;
        n = 0;
        for (int i = 0; i < 24; i++) if (i != 22 && p[i]) n++;
        return n;
    endfunction

    // Walk every in-range M/T slot of the loaded instruction against the model.
    task automatic checkAllSlots(input string tag, input logic [23:0] exp_pla);
        int g, len, ncyc, endk;
        byte ty;
        bit plus;
        g = group_of(exp_pla);
        cyc_info(g, 1, ty, len, plus, ncyc, endk);
        for (int m = 1; m <= ncyc; m++) begin
            cyc_info(g, m, ty, len, plus, ncyc, endk);
            for (int t = 1; t <= len; t++) begin
                setTiming(m, t);
                checkOutput(tag, 32'(dut_exec()), 32'(model_exec(g, bus.mcyc, bus.tst)));
            end
        end
    endtask

    // Run directed cases, the full sweep and the random phase, then summarize.
    initial begin
        logic [4:0] valid_pfx [6];
        logic [4:0] pfx;
        logic [7:0] opc;
        logic [23:0] ep;
        logic [5:0] mc, ts;
        int g, len, ncyc, endk, m, t;
        byte ty;
        bit plus;

        valid_pfx = '{5'b10100, 5'b10010, 5'b10001, 5'b01100, 5'b01010, 5'b01001};
        bus.prefix = 5'b10100;
        bus.opcode = 8'h76;
        bus.mcyc   = 6'b000001;
        bus.tst    = 6'b000001;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_pla", 32'(bus.pla), 32'h010000);
        setTiming(1, 4);
        checkOutput("reset_setM1", 32'(bus.setM1), 32'd1);
        checkOutput("reset_explode", 32'(bus.explode), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(5'b10100, 8'h76);
        setTiming(1, 4);
        checkOutput("halt_p3", 32'(bus.pla[3]), 32'd1);
        checkOutput("halt_setM1ss", 32'(bus.setM1ss), 32'd1);
        checkOutput("halt_setM1", 32'(bus.setM1), 32'd0);

        applyStimulus(5'b01100, 8'h36);
        checkOutput("ldhln_p5", 32'(bus.pla[5]), 32'd1);
        checkOutput("ldhln_p22", 32'(bus.pla[22]), 32'd1);
        setTiming(2, 1);
        checkOutput("ldhln_m2_mread", 32'(bus.fMRead), 32'd1);
        setTiming(2, 2);
        checkOutput("ldhln_m2t2_inccy", 32'(bus.ctl_inc_cy), 32'd1);
        setTiming(3, 3);
        checkOutput("ldhln_m3_mwrite", 32'(bus.fMWrite), 32'd1);
        checkOutput("ldhln_m3t3_setM1", 32'(bus.setM1), 32'd1);

        applyStimulus(5'b10001, 8'hB0);
        checkOutput("ldir_p21", 32'(bus.pla[21]), 32'd1);
        setTiming(3, 5);
        checkOutput("ldir_setM1bz", 32'(bus.setM1bz), 32'd1);
        checkOutput("ldir_mwrite", 32'(bus.fMWrite), 32'd1);

        applyStimulus(5'b10001, 8'h00);
        setTiming(1, 4);
        checkOutput("ed00_p23", 32'(bus.pla[23]), 32'd1);
        checkOutput("ed00_explode", 32'(bus.explode), 32'd1);

        applyStimulus(5'b11100, 8'h00);
        checkOutput("badpfx_pla", 32'(bus.pla), 32'h800000);

        applyStimulus(5'b10100, 8'h36);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_pla", 32'(bus.pla), 32'h010000);
        @(negedge clk);
        reset = 1'b0;

        bus.mcyc = 6'b000011;
        bus.tst  = 6'b000010;
        #1;
        checkOutput("nonhot_exec", 32'(dut_exec()), 32'(model_exec(16, bus.mcyc, bus.tst)));

        for (int p = 0; p < 6; p++) begin
            for (int o = 0; o < 256; o++) begin
                applyStimulus(valid_pfx[p], 8'(o));
                ep = model_pla(valid_pfx[p], 8'(o));
                checkOutput($sformatf("sweep_pla_%0h_%0h", valid_pfx[p], o), 32'(bus.pla), 32'(ep));
                checkOutput($sformatf("sweep_one_%0h_%0h", valid_pfx[p], o), 32'(line_count(bus.pla)), 32'd1);
                checkAllSlots($sformatf("sweep_exec_%0h_%0h", valid_pfx[p], o), ep);
            end
        end

        for (int k = 0; k < 400; k++) begin
            pfx = 5'($urandom);
            opc = 8'($urandom);
            applyStimulus(pfx, opc);
            ep = model_pla(pfx, opc);
            checkOutput($sformatf("rand_pla_%0h_%0h", pfx, opc), 32'(bus.pla), 32'(ep));
            g = group_of(ep);
            if ($urandom_range(0, 3) == 0) begin
                mc = 6'($urandom);
                ts = 6'($urandom);
                if ($onehot(mc)) mc = mc | 6'b100001;
            end else begin
                cyc_info(g, 1, ty, len, plus, ncyc, endk);
                m = $urandom_range(1, ncyc);
                cyc_info(g, m, ty, len, plus, ncyc, endk);
                t = $urandom_range(1, len);
                mc = 6'(1 << (m - 1));
                ts = 6'(1 << (t - 1));
            end
            bus.mcyc = mc;
            bus.tst  = ts;
            #1;
            checkOutput($sformatf("rand_exec_%0h_%0h_%0h_%0h", pfx, opc, mc, ts),
                        32'(dut_exec()), 32'(model_exec(g, mc, ts)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/z80_decode_exec_unit.md
Name: z80_decode_exec_unit

Overview:
Z80 instruction decode plus static-execute control block. It decodes the active prefix table and opcode byte into a registered 24-line PLA vector. From the PLA vector and the current machine cycle / T-state it combinationally drives cycle-type, sequencing and bus-control strobes. It sits between the instruction register and the bus/timing sequencer.

Parameters:
none

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
prefix  in  5  [4]=IXY0, [3]=IXY1, [2]=plain table, [1]=CB table, [0]=ED table
opcode  in  8  instruction byte
pla  out  24  registered decode lines p0..p23
mcyc  in  6  one-hot machine cycle M1..M6 (bit0=M1)
tst  in  6  one-hot T-state T1..T6 (bit0=T1)
nextM, setM1, setM1ss, setM1cc, setM1bz  out  1 each  sequencing strobes
fFetch, fMRead, fMWrite, fIORead, fIOWrite, fIntr  out  1 each  cycle-type flags
ctl_bus_sw1, ctl_bus_sw2, ctl_bus_sw4, ctl_al_we, ctl_inc_dec, ctl_inc_limit6, ctl_inc_cy, ctl_ab_mux_inc  out  1 each  datapath controls
explode  out  1  undecoded-opcode flag

Behaviour:
- pla register: loads decode(prefix, opcode) every clk. On reset it loads only p16 (NOP). Decode latency is 1 clk. Execute outputs are purely combinational from pla, mcyc and tst.
- Table select XX/CB/ED is valid only when prefix[2:0] is one-hot and prefix[4:3] is one-hot. If either is invalid, only p23 is set.
- r denotes op[2:0] or op[5:3]; value 110 denotes (HL).
- XX-table lines (op bits MSB first):
  - p0: 01 ddd sss, ddd≠110, sss≠110 (ld r,r')
  - p1: 01ddd110, ddd≠110 (ld r,(hl))
  - p2: 01110sss, sss≠110 (ld (hl),r)
  - p3: 0x76 (halt)
  - p4: 00ddd110, ddd≠110 (ld r,n)
  - p5: 0x36
  - p6: 10xxxsss, sss≠110
  - p7: 10xxx110
  - p8: 11xxx110
  - p9: 00ddd10x, ddd≠110
  - p10: 0xC3
  - p11: 11ccc010
  - p12: 0x18
  - p13: 0x10
  - p14: 0xD3
  - p15: 0xDB
  - p16: 0x00
- CB-table lines: p17 = 00xxxxxx; p18 = op[7:6]≠00.
- ED-table lines: p19 = 01rrr000; p20 = 01rrr001; p21 = 101xx000.
- p22 = IXY1 & (p1|p2|p5|p7 | XX op 0x34/0x35 | CB op[2:0]=110). It is a flag only, with no execute effect.
- p23 = valid table & none of p0..p21 set.
- Common execute rules:
  - fFetch=M1.
  - ctl_al_we=T1.
  - ctl_inc_limit6=M1&T3.
  - ctl_bus_sw1=T3&(fFetch|fMRead|fIORead).
  - ctl_bus_sw2=fMWrite|fIOWrite.
  - ctl_bus_sw4=M1&T4.
  - ctl_ab_mux_inc=ctl_inc_cy.
  - ctl_inc_cy=T2&(M1 | any operand read marked "+").
  - fIntr=0.
  - explode=p23&M1&T4.
  - Cycle-type flags are asserted for every T-state of their M-cycle.
  - nextM is asserted at the final T of every non-final M-cycle.
  - The end strobe is asserted at the final T of the final M-cycle.
  - If mcyc or tst is not one-hot, all execute outputs except fFetch are 0.
- Cycle list per group (T-count; end strobe):
  - p0, p6, p9, p16, p17, p18, p23: M1(4); setM1@M1T4.
  - p3: M1(4); setM1ss@M1T4.
  - p4, p8: M2 MRead+(3); setM1.
  - p1, p7: M2 MRead(3); setM1.
  - p2: M2 MWrite(3); setM1.
  - p5: M2 MRead+(3), M3 MWrite(3); setM1.
  - p10: M2 MRead+, M3 MRead+ (3 each); setM1@M3T3.
  - p11: as p10 but setM1cc@M3T3.
  - p12: M2 MRead+(3), M3 internal(5); setM1@M3T5.
  - p13: M1(5), ctl_inc_dec@M1T5; M2 MRead+(3) with setM1bz@M2T3; M3 internal(5); setM1@M3T5.
  - p14: M2 MRead+(3), M3 IOWrite(4); setM1.
  - p15: M2 MRead+(3), M3 IORead(4); setM1.
  - p19: M2 IORead(4); setM1.
  - p20: M2 IOWrite(4); setM1.
  - p21: M2 MRead(3), M3 MWrite(5); setM1bz@M3T5.
- Multiple end strobes are never asserted together.
- Reset mid-instruction reverts the pla register to NOP on the next clk.

Test Plan:
- Reset, then mcyc=M1, tst=T4 -> pla=0x010000 (p16), setM1=1, explode=0.
- prefix=10100, op=0x76, clk, M1T4 -> p3=1, setM1ss=1, setM1=0.
- prefix=01100, op=0x36, clk -> p5=1, p22=1; at M2 fMRead=1, ctl_inc_cy@T2=1; at M3T3 fMWrite=1, setM1=1.
- prefix=10001, op=0xB0, clk -> p21=1; at M3T5 setM1bz=1, fMWrite=1.
- prefix=10001, op=0x00, clk, M1T4 -> p23=1, explode=1.
- prefix=11100 (invalid), any op -> only p23 set. Also sweep ops 0..255 for each of the 6 valid prefixes and check exactly one of p0..p21/p23 is set.
